// File: rtl/alu54_add_arbiter_if.sv
// Bundle of signals between the two address generators, the arbiter and the
// shared ALU54D adder wrapper.
interface alu54_add_arbiter_if #(
   parameter int A_WIDTH   = 21,
   parameter int B_WIDTH   = 5,
   parameter int OUT_WIDTH = 22
);
   logic                 req0_valid;
   logic [A_WIDTH-1:0]   req0_a;
   logic [B_WIDTH-1:0]   req0_b;
   logic                 req0_ready;
   logic                 req1_valid;
   logic [A_WIDTH-1:0]   req1_a;
   logic [B_WIDTH-1:0]   req1_b;
   logic                 req1_ready;
   logic [A_WIDTH-1:0]   alu_a;
   logic [B_WIDTH-1:0]   alu_b;
   logic                 alu_ce;
   logic                 alu_reset;
   logic [OUT_WIDTH-1:0] alu_dout;
   logic                 rsp_valid;
   logic                 rsp_id;
   logic [OUT_WIDTH-1:0] rsp_data;

   // Requesters and the adder wrapper sit on the master side
   modport master (
      output req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, alu_dout,
      input  req0_ready, req1_ready, alu_a, alu_b, alu_ce, alu_reset,
             rsp_valid, rsp_id, rsp_data
   );

   modport slave (
      input  req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, alu_dout,
      output req0_ready, req1_ready, alu_a, alu_b, alu_ce, alu_reset,
             rsp_valid, rsp_id, rsp_data
   );
endinterface

// File: rtl/alu54_add_arbiter.sv
// Round-robin arbiter for the shared registered 21+5 bit adder; routes each
// sum back to its originator one cycle after issue.
module alu54_add_arbiter #(
   parameter int A_WIDTH   = 21,
   parameter int B_WIDTH   = 5,
   parameter int OUT_WIDTH = 22
) (
   input logic clk,
   input logic reset,
   alu54_add_arbiter_if.slave bus
);
   logic                 ptr;
   logic                 grant0;
   logic                 grant1;
   logic [A_WIDTH-1:0]   mux_a;
   logic [B_WIDTH-1:0]   mux_b;
   logic [OUT_WIDTH-1:0] sum;

   // Pointer only matters when both requesters contend
   always_comb begin
      grant0 = 1'b0;
      grant1 = 1'b0;
      if (!reset) begin
         grant0 = bus.req0_valid && (!bus.req1_valid || !ptr);
         grant1 = bus.req1_valid && (!bus.req0_valid ||  ptr);
      end
   end

   always_comb begin
      mux_a = '0;
      mux_b = '0;
      if (grant0) begin
         mux_a = bus.req0_a;
         mux_b = bus.req0_b;
      end else if (grant1) begin
         mux_a = bus.req1_a;
         mux_b = bus.req1_b;
      end
   end

   assign bus.req0_ready = grant0;
   assign bus.req1_ready = grant1;
   assign bus.alu_a      = mux_a;
   assign bus.alu_b      = mux_b;
   assign bus.alu_ce     = grant0 | grant1;
   assign bus.alu_reset  = reset;

   // rsp_valid doubles as the in-flight marker for the adder's single slot
   always_ff @(posedge clk) begin
      if (reset) begin
         ptr           <= 1'b0;
         bus.rsp_valid <= 1'b0;
         bus.rsp_id    <= 1'b0;
      end else begin
         bus.rsp_valid <= grant0 | grant1;
         if (grant0) begin
            ptr        <= 1'b1;
            bus.rsp_id <= 1'b0;
         end else if (grant1) begin
            ptr        <= 1'b0;
            bus.rsp_id <= 1'b1;
         end
      end
   end

   assign sum          = bus.alu_dout;
   assign bus.rsp_data = sum;
endmodule

// File: tb/tb_alu54_add_arbiter.sv
// Directed bench for alu54_add_arbiter with a behavioural adder model and a
// scoreboard queue drained by an independent response monitor.
module tb_alu54_add_arbiter;
   logic clk;
   logic reset;
   int   cyc;
   int   vectors;
   int   miscompares;

   typedef struct {
      int          due;
      logic        id;
      logic [21:0] data;
   } exp_t;

   exp_t exp_q[$];

   alu54_add_arbiter_if #(.A_WIDTH(21), .B_WIDTH(5), .OUT_WIDTH(22)) bus ();

   alu54_add_arbiter #(.A_WIDTH(21), .B_WIDTH(5), .OUT_WIDTH(22)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Registered adder: cleared by its reset, holds dout while ce is low
   always @(posedge clk) begin
      if (bus.alu_reset)
         bus.alu_dout <= '0;
      else if (bus.alu_ce)
         bus.alu_dout <= 22'(bus.alu_a) + 22'(bus.alu_b);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, req);
      end
   endtask

   // Monitor: every cycle the response valid must match the scoreboard head
   always @(negedge clk) begin
      logic exp_valid;
      exp_t e;
      exp_valid = (exp_q.size() > 0) && (exp_q[0].due == cyc);
      check("rsp_valid", 32'(bus.rsp_valid), 32'(exp_valid));
      if (exp_valid) begin
         e = exp_q.pop_front();
         check("rsp_id", 32'(bus.rsp_id), 32'(e.id));
         check("rsp_data", 32'(bus.rsp_data), 32'(e.data));
      end
   end

   task automatic apply_stimulus(
      input logic        rst,
      input logic        v0, input logic [20:0] a0, input logic [4:0] b0,
      input logic        v1, input logic [20:0] a1, input logic [4:0] b1,
      input logic        g0, input logic g1,
      input logic [21:0] exp_sum
   );
      exp_t e;
      @(posedge clk);
      #1;
      reset          = rst;
      bus.req0_valid = v0;
      bus.req0_a     = a0;
      bus.req0_b     = b0;
      bus.req1_valid = v1;
      bus.req1_a     = a1;
      bus.req1_b     = b1;
      @(negedge clk);
      check("req0_ready", 32'(bus.req0_ready), 32'(g0));
      check("req1_ready", 32'(bus.req1_ready), 32'(g1));
      check("alu_ce", 32'(bus.alu_ce), 32'(g0 | g1));
      check("alu_reset", 32'(bus.alu_reset), 32'(rst));
      if (g0 | g1) begin
         check("alu_a", 32'(bus.alu_a), 32'(g0 ? a0 : a1));
         check("alu_b", 32'(bus.alu_b), 32'(g0 ? b0 : b1));
         e.due  = cyc + 1;
         e.id   = g1;
         e.data = exp_sum;
         exp_q.push_back(e);
      end else begin
         check("alu_a_idle", 32'(bus.alu_a), 32'd0);
      end
   endtask

   task automatic idle_cycle();
      apply_stimulus(1'b0, 1'b0, 21'h0, 5'h0, 1'b0, 21'h0, 5'h0, 1'b0, 1'b0, 22'h0);
   endtask

   task automatic check_output(input string name, input logic [21:0] req_data);
      check(name, 32'(bus.rsp_data), 32'(req_data));
   endtask

   initial begin
      vectors        = 0;
      miscompares    = 0;
      cyc            = 0;
      reset          = 1'b1;
      bus.req0_valid = 1'b0;
      bus.req0_a     = '0;
      bus.req0_b     = '0;
      bus.req1_valid = 1'b0;
      bus.req1_a     = '0;
      bus.req1_b     = '0;

      // Reset held three cycles with requester 0 pending
      for (int i = 0; i < 3; i++)
         apply_stimulus(1'b1, 1'b1, 21'h10, 5'h01, 1'b0, 21'h0, 5'h0, 1'b0, 1'b0, 22'h0);
      check("rsp_id_reset", 32'(bus.rsp_id), 32'd0);
      apply_stimulus(1'b0, 1'b1, 21'h10, 5'h01, 1'b0, 21'h0, 5'h0, 1'b1, 1'b0, 22'h000011);

      // Single op and max operands
      apply_stimulus(1'b0, 1'b1, 21'h000100, 5'h05, 1'b0, 21'h0, 5'h0, 1'b1, 1'b0, 22'h000105);
      idle_cycle();
      apply_stimulus(1'b0, 1'b0, 21'h0, 5'h0, 1'b1, 21'h1FFFFF, 5'h1F, 1'b0, 1'b1, 22'h20001E);

      // Six cycles of contention, each requester holding operands until granted
      apply_stimulus(1'b0, 1'b1, 21'h00A000, 5'h01, 1'b1, 21'h0B0000, 5'h02, 1'b1, 1'b0, 22'h00A001);
      apply_stimulus(1'b0, 1'b1, 21'h00A100, 5'h03, 1'b1, 21'h0B0000, 5'h02, 1'b0, 1'b1, 22'h0B0002);
      apply_stimulus(1'b0, 1'b1, 21'h00A100, 5'h03, 1'b1, 21'h0B1000, 5'h04, 1'b1, 1'b0, 22'h00A103);
      apply_stimulus(1'b0, 1'b1, 21'h00A200, 5'h1F, 1'b1, 21'h0B1000, 5'h04, 1'b0, 1'b1, 22'h0B1004);
      apply_stimulus(1'b0, 1'b1, 21'h00A200, 5'h1F, 1'b1, 21'h1FFFF0, 5'h10, 1'b1, 1'b0, 22'h00A21F);
      apply_stimulus(1'b0, 1'b1, 21'h0, 5'h0, 1'b1, 21'h1FFFF0, 5'h10, 1'b0, 1'b1, 22'h200000);

      // Idle gap: dout holds the previous sum while ce is low
      apply_stimulus(1'b0, 1'b1, 21'h001234, 5'h03, 1'b0, 21'h0, 5'h0, 1'b1, 1'b0, 22'h001237);
      idle_cycle();
      check_output("rsp_data_gap1", 22'h001237);
      idle_cycle();
      check_output("rsp_data_gap2", 22'h001237);
      apply_stimulus(1'b0, 1'b0, 21'h0, 5'h0, 1'b1, 21'h0ABCDE, 5'h10, 1'b0, 1'b1, 22'h0ABCEE);

      // Reset lands while requester 1 would be granted; pointer returns to 0
      apply_stimulus(1'b0, 1'b1, 21'h000020, 5'h02, 1'b0, 21'h0, 5'h0, 1'b1, 1'b0, 22'h000022);
      apply_stimulus(1'b1, 1'b0, 21'h0, 5'h0, 1'b1, 21'h000300, 5'h07, 1'b0, 1'b0, 22'h0);
      apply_stimulus(1'b0, 1'b1, 21'h000400, 5'h09, 1'b1, 21'h000300, 5'h07, 1'b1, 1'b0, 22'h000409);
      apply_stimulus(1'b0, 1'b0, 21'h0, 5'h0, 1'b1, 21'h000300, 5'h07, 1'b0, 1'b1, 22'h000307);

      for (int i = 0; i < 3; i++)
         idle_cycle();
      check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
